window_loader: RTL and testbench
================================

WINDOW_LOADER -- requirements
Module: window_loader

Interface
REQ-001 The block SHALL be a single-clock design; reset is synchronous and active-high.
REQ-002 Parameter KERNEL_SIZE, default 3, SHALL be the window side length; window elements = KERNEL_SIZE*KERNEL_SIZE.
REQ-003 Parameter DATA_WIDTH, default 8, SHALL be the pixel width.
REQ-004 Parameter BRAM_ADDR_WIDTH, default 10, SHALL be the image BRAM address width.
REQ-005 Parameter IMG_WIDTH, default 28, SHALL be the image row pitch in pixels.
REQ-006 Parameter WIN_ADDR_WIDTH, default 4, SHALL be the window register address width.
REQ-007 i_clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-008 i_rst  input  1  SHALL be the synchronous active-high reset.
REQ-009 i_start  input  1  SHALL request one window load; level-sampled.
REQ-010 i_base_addr  input  BRAM_ADDR_WIDTH  SHALL be the BRAM address of the window's top-left pixel.
REQ-011 i_buf_sel  input  1  SHALL select the target window register: 0 = window1, 1 = window2.
REQ-012 o_bram_addr  output  BRAM_ADDR_WIDTH  SHALL be the registered BRAM read address.
REQ-013 i_bram_data  input  DATA_WIDTH  SHALL be BRAM read data, valid one cycle after its address.
REQ-014 o_wr_en1 / o_wr_en2  output  1 each  SHALL be the write enables for window1 and window2.
REQ-015 o_wr_addr  output  WIN_ADDR_WIDTH  SHALL be the window element index being written.
REQ-016 o_wr_data  output  DATA_WIDTH  SHALL equal i_bram_data combinationally.
REQ-017 o_busy  output  1  SHALL be high while a load is in progress.
REQ-018 o_done  output  1  SHALL be a one-cycle completion pulse.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, DONE; reset state IDLE.
REQ-020 In IDLE, i_start=1 SHALL be accepted at the clock edge: i_base_addr and i_buf_sel are captured, and the state becomes FETCH.
REQ-021 i_start SHALL be ignored in FETCH and DONE; captured inputs SHALL NOT change mid-load.
REQ-022 Element order SHALL be row-major: k = r*KERNEL_SIZE + c with r, c in 0..KERNEL_SIZE-1.
REQ-023 Element k SHALL be read from base + r*IMG_WIDTH + c, modulo 2^BRAM_ADDR_WIDTH (wrap, no error).
REQ-024 Addresses SHALL be generated with a column counter plus a row-start register incremented by IMG_WIDTH; no multiplier.
REQ-025 Counting the accept edge as cycle 0, o_bram_addr for element k SHALL be driven during cycle k+1.
REQ-026 The write for element k SHALL occur during cycle k+2: selected o_wr_en high, o_wr_addr = k, o_wr_data = i_bram_data.
REQ-027 At most one of o_wr_en1/o_wr_en2 SHALL be high in any cycle, and never outside write cycles.
REQ-028 o_busy SHALL be high in cycles 1 through KERNEL_SIZE^2+1 (cycles 1..10 for K=3).
REQ-029 o_done SHALL be high only in cycle KERNEL_SIZE^2+2 (cycle 11); the FSM SHALL be in DONE then, and return to IDLE the next cycle.
REQ-030 Earliest next accept SHALL be the cycle after o_done; back-to-back loads SHALL have no lost or duplicated writes.
REQ-031 o_bram_addr SHALL hold its last value when not fetching.

Reset
REQ-032 i_rst=1 SHALL force IDLE and clear all counters.
REQ-033 After reset, o_bram_addr, o_wr_addr, o_wr_en1, o_wr_en2, o_busy and o_done SHALL be 0 in the cycle after the reset edge.
REQ-034 Reset mid-load SHALL abort the load with no further writes and no o_done; i_start asserted together with i_rst SHALL be ignored.

Verification
REQ-035 base=0, buf_sel=0, BRAM data=addr[7:0]:
- o_bram_addr SHALL be 0,1,2,28,29,30,56,57,58.
- window1 addr 0..8 SHALL receive the same values.
- o_wr_en2 SHALL never be asserted.
- o_done SHALL pulse in cycle 11.
REQ-036 base=1020, buf_sel=1: addresses SHALL be 1020,1021,1022,24,25,26,52,53,54; only o_wr_en2 SHALL assert.
REQ-037 i_start held high for the whole load: exactly 9 writes; second accept SHALL occur the cycle after o_done, with 9 more writes.
REQ-038 i_start pulsed at cycle 4 of a load: SHALL be ignored; 9 writes and a single o_done.
REQ-039 i_rst at cycle 5 of a load: writes stop; outputs SHALL be 0 from cycle 6; no o_done; a subsequent load SHALL complete normally.
REQ-040 IMG_WIDTH=8, KERNEL_SIZE=2, base=3: addresses SHALL be 3,4,11,12; o_done SHALL pulse in cycle 6.

Source files
------------

// File: rtl/window_loader.sv
// Fetches a KERNEL_SIZE x KERNEL_SIZE pixel window from image BRAM in row-major
// order and writes it into one of two window registers through a one-cycle read pipeline.
module window_loader #(
  parameter int KERNEL_SIZE     = 3,
  parameter int DATA_WIDTH      = 8,
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int IMG_WIDTH       = 28,
  parameter int WIN_ADDR_WIDTH  = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [BRAM_ADDR_WIDTH-1:0] i_base_addr,
  input  logic                       i_buf_sel,
  output logic [BRAM_ADDR_WIDTH-1:0] o_bram_addr,
  input  logic [DATA_WIDTH-1:0]      i_bram_data,
  output logic                       o_wr_en1,
  output logic                       o_wr_en2,
  output logic [WIN_ADDR_WIDTH-1:0]  o_wr_addr,
  output logic [DATA_WIDTH-1:0]      o_wr_data,
  output logic                       o_busy,
  output logic                       o_done,
  output logic [1:0]                 o_state
);

  localparam int N_ELEM = KERNEL_SIZE * KERNEL_SIZE;
  localparam int COL_W  = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;

  localparam logic [COL_W-1:0]           COL_LAST = COL_W'(KERNEL_SIZE - 1);
  localparam logic [COL_W-1:0]           COL_ONE  = COL_W'(1);
  localparam logic [WIN_ADDR_WIDTH-1:0]  IDX_LAST = WIN_ADDR_WIDTH'(N_ELEM - 1);
  localparam logic [WIN_ADDR_WIDTH-1:0]  IDX_ONE  = WIN_ADDR_WIDTH'(1);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ROW_STEP = BRAM_ADDR_WIDTH'(IMG_WIDTH);
  localparam logic [BRAM_ADDR_WIDTH-1:0] ADDR_ONE = BRAM_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   accept;

  logic                       buf_sel_q;
  logic [BRAM_ADDR_WIDTH-1:0] row_start;
  logic [COL_W-1:0]           col;
  logic                       rd_valid;
  logic [WIN_ADDR_WIDTH-1:0]  rd_idx;
  logic                       wr_valid;
  logic [WIN_ADDR_WIDTH-1:0]  wr_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Request handshake: i_start is a level request taken only while IDLE (o_busy and
  // o_done both low); once taken, o_busy stays high until the last element is
  // written, o_done pulses for one cycle, and the next request can be taken after it.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          accept    = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        o_busy = 1'b1;
        if (wr_valid && (wr_idx == IDX_LAST)) state_nxt = DONE;
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Read side walks the window with a column counter and a row-start pointer; the
  // write side trails it by one cycle to match the BRAM read latency.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      buf_sel_q   <= 1'b0;
      row_start   <= '0;
      col         <= '0;
      o_bram_addr <= '0;
      rd_valid    <= 1'b0;
      rd_idx      <= '0;
      wr_valid    <= 1'b0;
      wr_idx      <= '0;
    end else begin
      wr_valid <= rd_valid;
      if (rd_valid) wr_idx <= rd_idx;

      if (accept) begin
        buf_sel_q   <= i_buf_sel;
        row_start   <= i_base_addr;
        o_bram_addr <= i_base_addr;
        col         <= '0;
        rd_idx      <= '0;
        rd_valid    <= 1'b1;
      end else if (rd_valid) begin
        if (rd_idx == IDX_LAST) begin
          rd_valid <= 1'b0;
        end else begin
          rd_idx <= rd_idx + IDX_ONE;
          if (col == COL_LAST) begin
            col         <= '0;
            row_start   <= row_start + ROW_STEP;
            o_bram_addr <= row_start + ROW_STEP;
          end else begin
            col         <= col + COL_ONE;
            o_bram_addr <= o_bram_addr + ADDR_ONE;
          end
        end
      end
    end
  end

  assign o_wr_en1  = wr_valid & ~buf_sel_q;
  assign o_wr_en2  = wr_valid &  buf_sel_q;
  assign o_wr_addr = wr_idx;
  assign o_wr_data = i_bram_data;
  assign o_state   = state;

endmodule

// File: tb/tb_window_loader.sv
// Bench for window_loader: a 3x3/pitch-28 instance and a 2x2/pitch-8 instance share
// a BRAM model; per-cycle observations are checked against a timeline built from the window rules.
module tb_window_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       use2 = 1'b0;
  logic       sel = 1'b0;
  logic [9:0] base = '0;
  logic       start1, start2;
  assign start1 = start & ~use2;
  assign start2 = start &  use2;

  logic [9:0] addr1, addr2;
  logic [7:0] data1, data2, wdata1, wdata2;
  logic       we1_1, we2_1, we1_2, we2_2, busy1, busy2, done1, done2;
  logic [3:0] waddr1, waddr2;
  logic [1:0] state1, state2;

  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    data1 <= mem[addr1];
    data2 <= mem[addr2];
  end

  window_loader dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_base_addr(base), .i_buf_sel(sel),
    .o_bram_addr(addr1), .i_bram_data(data1), .o_wr_en1(we1_1), .o_wr_en2(we2_1),
    .o_wr_addr(waddr1), .o_wr_data(wdata1), .o_busy(busy1), .o_done(done1), .o_state(state1)
  );

  window_loader #(.KERNEL_SIZE(2), .IMG_WIDTH(8)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_base_addr(base), .i_buf_sel(sel),
    .o_bram_addr(addr2), .i_bram_data(data2), .o_wr_en1(we1_2), .o_wr_en2(we2_2),
    .o_wr_addr(waddr2), .o_wr_data(wdata2), .o_busy(busy2), .o_done(done2), .o_state(state2)
  );

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       we1;
    logic       we2;
    logic [3:0] waddr;
    logic [9:0] addr;
    logic [7:0] wdata;
  } obs_t;

  obs_t cap [0:63];
  obs_t exp_o [0:63];
  obs_t msk [0:63];

  int tests_run = 0;
  int failed = 0;

  task automatic fill_mem(input bit ramp);
    for (int i = 0; i < 1024; i++) mem[i] = ramp ? 8'(i) : 8'($urandom);
  endtask

  task automatic model_clear();
    for (int n = 0; n < 64; n++) begin
      exp_o[n] = '0;
      msk[n] = '0;
      msk[n].busy = 1'b1;
      msk[n].done = 1'b1;
      msk[n].we1 = 1'b1;
      msk[n].we2 = 1'b1;
    end
  endtask

  // One load accepted at the end of cycle c0; abort = cycle during which reset is held.
  task automatic model_add_load(input int c0, input int b, input bit s, input int ks,
                                input int img, input int abort);
    int nel, a, r, c;
    nel = ks * ks;
    for (int k = 0; k < nel; k++) begin
      r = k / ks;
      c = k % ks;
      a = (b + r * img + c) % 1024;
      if (c0 + 1 + k <= abort && c0 + 1 + k < 64) begin
        exp_o[c0 + 1 + k].addr = 10'(a);
        msk[c0 + 1 + k].addr = '1;
      end
      if (c0 + 2 + k <= abort && c0 + 2 + k < 64) begin
        if (s) exp_o[c0 + 2 + k].we2 = 1'b1;
        else   exp_o[c0 + 2 + k].we1 = 1'b1;
        exp_o[c0 + 2 + k].waddr = 4'(k);
        exp_o[c0 + 2 + k].wdata = mem[a];
        msk[c0 + 2 + k].waddr = '1;
        msk[c0 + 2 + k].wdata = '1;
      end
    end
    for (int n = c0 + 1; n <= c0 + nel + 1; n++)
      if (n <= abort && n < 64) exp_o[n].busy = 1'b1;
    if (c0 + nel + 2 <= abort && c0 + nel + 2 < 64) exp_o[c0 + nel + 2].done = 1'b1;
    for (int n = abort + 1; n < 64; n++) begin
      exp_o[n].addr = '0;
      exp_o[n].waddr = '0;
      msk[n].addr = '1;
      msk[n].waddr = '1;
    end
  endtask

  // Issues a request, then records cycles 1..ncyc; start is re-driven high while
  // n < hold_until or at n == pulse_at, reset is driven during cycle rst_at.
  task automatic run(input int ncyc, input int hold_until, input int pulse_at, input int rst_at,
                     input logic [9:0] b, input logic s, input bit scramble);
    @(negedge clk);
    base = b;
    sel = s;
    start = 1'b1;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clk);
      cap[n].busy  = use2 ? busy2  : busy1;
      cap[n].done  = use2 ? done2  : done1;
      cap[n].we1   = use2 ? we1_2  : we1_1;
      cap[n].we2   = use2 ? we2_2  : we2_1;
      cap[n].waddr = use2 ? waddr2 : waddr1;
      cap[n].addr  = use2 ? addr2  : addr1;
      cap[n].wdata = use2 ? wdata2 : wdata1;
      start = (n < hold_until) || (n == pulse_at);
      rst = (n == rst_at);
      if (n == 1 && scramble) begin
        base = 10'($urandom);
        sel = ~s;
      end
    end
    start = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    base = 10'd77;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if ({addr1, waddr1, we1_1, we2_1, busy1, done1} !== 18'd0 ||
          {addr2, waddr2, we1_2, we2_2, busy2, done2} !== 18'd0) begin
        failed++;
        $display("FAIL reset_outputs i=%0d got a=%0d wa=%0d we=%b%b busy=%b done=%b / a=%0d wa=%0d we=%b%b busy=%b done=%b required all 0",
                 i, addr1, waddr1, we1_1, we2_1, busy1, done1, addr2, waddr2, we1_2, we2_2, busy2, done2);
      end
    end
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if ({busy1, busy2, we1_1, we2_1} !== 4'b0) begin
        failed++;
        $display("FAIL reset_start_ignored i=%0d got busy=%b%b we=%b%b required 0", i, busy1, busy2, we1_1, we2_1);
      end
    end
  endtask

  task automatic test_basic();
    use2 = 1'b0;
    fill_mem(1'b1);
    model_clear();
    model_add_load(0, 0, 1'b0, 3, 28, 1000);
    run(14, 1, 0, 0, 10'd0, 1'b0, 1'b1);
    for (int n = 1; n <= 14; n++) begin
      tests_run++;
      if ((cap[n] & msk[n]) !== (exp_o[n] & msk[n])) begin
        failed++;
        $display("FAIL basic cyc=%0d got %h required %h (mask %h)", n, cap[n], exp_o[n], msk[n]);
      end
    end
  endtask

  task automatic test_wrap();
    use2 = 1'b0;
    fill_mem(1'b0);
    model_clear();
    model_add_load(0, 1020, 1'b1, 3, 28, 1000);
    run(14, 1, 0, 0, 10'd1020, 1'b1, 1'b1);
    for (int n = 1; n <= 14; n++) begin
      tests_run++;
      if ((cap[n] & msk[n]) !== (exp_o[n] & msk[n])) begin
        failed++;
        $display("FAIL wrap cyc=%0d got %h required %h (mask %h)", n, cap[n], exp_o[n], msk[n]);
      end
    end
  endtask

  task automatic test_random();
    logic [9:0] b;
    logic s;
    use2 = 1'b0;
    for (int t = 0; t < 6; t++) begin
      fill_mem(1'b0);
      b = 10'($urandom);
      s = 1'($urandom_range(0, 1));
      model_clear();
      model_add_load(0, int'(b), s, 3, 28, 1000);
      run(13, 1, 0, 0, b, s, 1'b1);
      for (int n = 1; n <= 13; n++) begin
        tests_run++;
        if ((cap[n] & msk[n]) !== (exp_o[n] & msk[n])) begin
          failed++;
          $display("FAIL random t=%0d base=%0d sel=%b cyc=%0d got %h required %h", t, b, s, n, cap[n], exp_o[n]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] b;
    use2 = 1'b0;
    fill_mem(1'b0);
    b = 10'($urandom);
    model_clear();
    model_add_load(0, int'(b), 1'b1, 3, 28, 1000);
    model_add_load(12, int'(b), 1'b1, 3, 28, 1000);
    run(26, 23, 0, 0, b, 1'b1, 1'b0);
    for (int n = 1; n <= 26; n++) begin
      tests_run++;
      if ((cap[n] & msk[n]) !== (exp_o[n] & msk[n])) begin
        failed++;
        $display("FAIL back_to_back cyc=%0d got %h required %h", n, cap[n], exp_o[n]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [9:0] b;
    use2 = 1'b0;
    fill_mem(1'b0);
    b = 10'($urandom);
    model_clear();
    model_add_load(0, int'(b), 1'b0, 3, 28, 1000);
    run(16, 1, 4, 0, b, 1'b0, 1'b1);
    for (int n = 1; n <= 16; n++) begin
      tests_run++;
      if ((cap[n] & msk[n]) !== (exp_o[n] & msk[n])) begin
        failed++;
        $display("FAIL start_ignored cyc=%0d got %h required %h", n, cap[n], exp_o[n]);
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [9:0] b;
    use2 = 1'b0;
    fill_mem(1'b0);
    b = 10'($urandom);
    model_clear();
    model_add_load(0, int'(b), 1'b1, 3, 28, 5);
    run(13, 1, 0, 5, b, 1'b1, 1'b1);
    for (int n = 1; n <= 13; n++) begin
      tests_run++;
      if ((cap[n] & msk[n]) !== (exp_o[n] & msk[n])) begin
        failed++;
        $display("FAIL reset_abort cyc=%0d got %h required %h", n, cap[n], exp_o[n]);
      end
    end
    b = 10'($urandom);
    model_clear();
    model_add_load(0, int'(b), 1'b0, 3, 28, 1000);
    run(13, 1, 0, 0, b, 1'b0, 1'b1);
    for (int n = 1; n <= 13; n++) begin
      tests_run++;
      if ((cap[n] & msk[n]) !== (exp_o[n] & msk[n])) begin
        failed++;
        $display("FAIL reset_recover cyc=%0d got %h required %h", n, cap[n], exp_o[n]);
      end
    end
  endtask

  task automatic test_small_kernel();
    use2 = 1'b1;
    fill_mem(1'b0);
    model_clear();
    model_add_load(0, 3, 1'b0, 2, 8, 1000);
    run(9, 1, 0, 0, 10'd3, 1'b0, 1'b1);
    for (int n = 1; n <= 9; n++) begin
      tests_run++;
      if ((cap[n] & msk[n]) !== (exp_o[n] & msk[n])) begin
        failed++;
        $display("FAIL small_kernel cyc=%0d got %h required %h", n, cap[n], exp_o[n]);
      end
    end
    use2 = 1'b0;
  endtask

  initial begin
    fill_mem(1'b1);
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_wrap();
    test_random();
    test_back_to_back();
    test_start_ignored();
    test_reset_abort();
    test_small_kernel();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
